// File: rtl/note_seq_pkg.sv
// Shared definitions for the note sequencer.
//   state_t : FSM encoding (IDLE / LOAD / PLAY / GAP)
//   step_t  : one step RAM record {peak, dur}
//   PEAK_W  : triangle peak / sample width
//   DUR_W   : note duration width in ticks
package note_seq_pkg;

  localparam int PEAK_W = 12;
  localparam int DUR_W  = 16;
  localparam int REC_W  = PEAK_W + DUR_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  typedef struct packed {
    logic [PEAK_W-1:0] peak;
    logic [DUR_W-1:0]  dur;
  } step_t;

endpackage

// File: rtl/tri_osc.sv
// Programmable-peak triangle generator, one count step per enabled clock.
// Produces 0,1..peak,peak-1..0,1.. (period 2*peak); clr restarts at 0 counting up.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   en         : advance the waveform this cycle
//   clr        : restart at 0, direction up (has priority over en)
//   peak       : turning point of the waveform (must be nonzero while en=1)
//   sample     : current triangle value
module tri_osc
  import note_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clr,
  input  logic [PEAK_W-1:0] peak,
  output logic [PEAK_W-1:0] sample
);

  logic              up;
  logic [PEAK_W-1:0] inc;
  logic [PEAK_W-1:0] dec;

  assign inc = sample + PEAK_W'(1);
  assign dec = sample - PEAK_W'(1);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      sample <= '0;
      up     <= 1'b1;
    end else if (en) begin
      // The direction flips on the same edge the turning value is reached,
      // so the peak and the zero are each held for exactly one sample.
      if (up) begin
        sample <= inc;
        if (inc == peak) up <= 1'b0;
      end else begin
        sample <= dec;
        if (dec == '0) up <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Melody player: steps through a small RAM of {peak, dur} records and plays
// each as a triangle tone lasting dur ticks (TICK_DIV clocks per tick).
// Build option: define SEQ_GAP_EN to insert GAP_TICKS silent ticks after
// every note; without it notes play back-to-back and no GAP state exists.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start / stop        : 1-cycle pulses; stop aborts and wins over start
//   loop_en             : wrap to step 0 at the end of the melody
//   prog_we/addr/peak/dur : step RAM write port, ignored while busy
//   busy                : FSM not idle
//   step_idx            : step currently loaded/playing
//   note_on             : audible tone (PLAY with nonzero peak)
//   done                : 1-cycle pulse on natural end of melody
//   signal              : triangle sample, 0 when note_on=0
module note_sequencer
  import note_seq_pkg::*;
#(
  parameter  int NUM_STEPS = 16,
  parameter  int TICK_DIV  = 100000,
  parameter  int GAP_TICKS = 10,
  localparam int AW        = $clog2(NUM_STEPS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic              prog_we,
  input  logic [AW-1:0]     prog_addr,
  input  logic [PEAK_W-1:0] prog_peak,
  input  logic [DUR_W-1:0]  prog_dur,
  output logic              busy,
  output logic [AW-1:0]     step_idx,
  output logic              note_on,
  output logic              done,
  output logic [PEAK_W-1:0] signal
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  // One tick counter serves both the note duration and the gap length,
  // so it must be wide enough for either.
  localparam int GAP_W = $clog2(GAP_TICKS + 1);
  localparam int CNT_W = (GAP_W > DUR_W) ? GAP_W : DUR_W;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [AW-1:0]    LAST_STEP = AW'(NUM_STEPS - 1);

  state_t              state, state_nxt;
  logic [AW-1:0]       step_nxt;
  logic                done_nxt;
  logic                done_r;

  step_t               ram [NUM_STEPS];
  step_t               rd_step;

  logic [PEAK_W-1:0]   peak_r;
  logic [DUR_W-1:0]    dur_r;
  logic [DIV_W-1:0]    div_cnt;
  logic [CNT_W-1:0]    tick_cnt;
  logic [CNT_W-1:0]    cnt_last;
  logic                tick;
  logic                tick_last;

  state_t              adv_state;
  logic [AW-1:0]       adv_step;
  logic                adv_done;

  logic                osc_en;
  logic                osc_clr;
  logic [PEAK_W-1:0]   osc_sample;
  logic                tone;

  // Step RAM: write only while idle, asynchronous read of the current step.
  always_ff @(posedge clk) begin
    if (prog_we && (state == ST_IDLE)) begin
      ram[prog_addr] <= '{peak: prog_peak, dur: prog_dur};
    end
  end

  assign rd_step = ram[step_idx];

  // Tick and duration/gap end detection
  assign tick = (div_cnt == DIV_LAST);

  always_comb begin
    cnt_last = CNT_W'(dur_r) - CNT_W'(1);
`ifdef SEQ_GAP_EN
    if (state == ST_GAP) cnt_last = CNT_W'(GAP_TICKS - 1);
`endif
  end

  assign tick_last = tick && (tick_cnt == cnt_last);

  // Where to go once a step has finished playing (and its gap, if built).
  always_comb begin
    adv_state = ST_LOAD;
    adv_step  = step_idx + AW'(1);
    adv_done  = 1'b0;
    if (step_idx == LAST_STEP) begin
      adv_step = '0;
      if (!loop_en) begin
        adv_state = ST_IDLE;
        adv_done  = 1'b1;
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    step_nxt  = step_idx;
    done_nxt  = 1'b0;
    if (stop) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state_nxt = ST_LOAD;
            step_nxt  = '0;
          end
        end
        ST_LOAD: begin
          if (rd_step.dur == '0) begin
            // End marker: a marker at step 0 never loops, which rules out
            // spinning in LOAD on an empty melody.
            if (loop_en && (step_idx != '0)) begin
              state_nxt = ST_LOAD;
              step_nxt  = '0;
            end else begin
              state_nxt = ST_IDLE;
              done_nxt  = 1'b1;
            end
          end else begin
            state_nxt = ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (tick_last) begin
`ifdef SEQ_GAP_EN
            state_nxt = ST_GAP;
`else
            state_nxt = adv_state;
            step_nxt  = adv_step;
            done_nxt  = adv_done;
`endif
          end
        end
`ifdef SEQ_GAP_EN
        ST_GAP: begin
          if (tick_last) begin
            state_nxt = adv_state;
            step_nxt  = adv_step;
            done_nxt  = adv_done;
          end
        end
`endif
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    tone    = (state == ST_PLAY) && (peak_r != '0);
    busy    = (state != ST_IDLE);
    note_on = tone;
    signal  = tone ? osc_sample : '0;
    osc_en  = tone;
    osc_clr = (state == ST_LOAD);
  end

  assign done = done_r;

  // Step index, latched note, tick divider and tick counter
  always_ff @(posedge clk) begin
    if (reset) begin
      step_idx <= '0;
      done_r   <= 1'b0;
      peak_r   <= '0;
      dur_r    <= '0;
      div_cnt  <= '0;
      tick_cnt <= '0;
    end else begin
      step_idx <= step_nxt;
      done_r   <= done_nxt;
      case (state)
        ST_LOAD: begin
          if (rd_step.dur != '0) begin
            peak_r <= rd_step.peak;
            dur_r  <= rd_step.dur;
          end
          div_cnt  <= '0;
          tick_cnt <= '0;
        end
        ST_PLAY, ST_GAP: begin
          // Counters wrap at the end of a note so a following gap starts clean.
          if (tick) begin
            div_cnt  <= '0;
            tick_cnt <= tick_last ? '0 : tick_cnt + CNT_W'(1);
          end else begin
            div_cnt  <= div_cnt + DIV_W'(1);
          end
        end
        default: begin
          div_cnt  <= '0;
          tick_cnt <= '0;
        end
      endcase
    end
  end

  tri_osc u_osc (
    .clk    (clk),
    .reset  (reset),
    .en     (osc_en),
    .clr    (osc_clr),
    .peak   (peak_r),
    .sample (osc_sample)
  );

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with TICK_DIV=4, NUM_STEPS=4, GAP_TICKS=2.
// Works in both builds; with SEQ_GAP_EN every note is followed by
// GAP_TICKS*TICK_DIV silent cycles.
module tb_note_sequencer;

  localparam int NUM_STEPS = 4;
  localparam int TICK_DIV  = 4;
  localparam int GAP_TICKS = 2;
`ifdef SEQ_GAP_EN
  localparam int GAPC = GAP_TICKS * TICK_DIV;
`else
  localparam int GAPC = 0;
`endif
  // Cycles from the first PLAY cycle of one dur=1 step to the next one:
  // 4 PLAY + gap + 1 LOAD.
  localparam int P1 = TICK_DIV + GAPC + 1;

  logic        clk = 1'b0;
  logic        reset, start, stop, loop_en, prog_we;
  logic [1:0]  prog_addr;
  logic [11:0] prog_peak;
  logic [15:0] prog_dur;
  logic        busy, note_on, done;
  logic [1:0]  step_idx;
  logic [11:0] signal;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;

  note_sequencer #(
    .NUM_STEPS (NUM_STEPS),
    .TICK_DIV  (TICK_DIV),
    .GAP_TICKS (GAP_TICKS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .loop_en   (loop_en),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_peak (prog_peak),
    .prog_dur  (prog_dur),
    .busy      (busy),
    .step_idx  (step_idx),
    .note_on   (note_on),
    .done      (done),
    .signal    (signal)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input int addr, input int peak, input int dur);
    prog_addr = 2'(addr);
    prog_peak = 12'(peak);
    prog_dur  = 16'(dur);
    prog_we   = 1'b1;
    cyc();
    prog_we   = 1'b0;
  endtask

  // Returns in the LOAD cycle of step 0.
  task automatic start_pulse();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 300) begin
      cyc();
      n++;
    end
    chk(tag, done, 1);
  endtask

  // Melody {3,2},{0,1},{5,0}: full expected trace from start to done.
  task automatic check_melody1(input string tag);
    logic [11:0] tri3 [8] = '{0, 1, 2, 3, 2, 1, 0, 1};
    int bad = 0;
    start_pulse();
    chk({tag, "_load_busy"}, busy, 1);
    chk({tag, "_load_step"}, step_idx, 0);
    chk({tag, "_load_quiet"}, note_on, 0);
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk({tag, "_tri"}, signal, tri3[i]);
      chk({tag, "_on"}, note_on, 1);
    end
    for (int i = 0; i < GAPC; i++) begin
      cyc();
      if (note_on !== 1'b0 || signal !== 12'd0) bad++;
    end
    chk({tag, "_gap1_quiet"}, bad, 0);
    cyc();
    chk({tag, "_step1"}, step_idx, 1);
    for (int i = 0; i < TICK_DIV + GAPC; i++) begin
      cyc();
      if (note_on !== 1'b0 || signal !== 12'd0 || busy !== 1'b1) bad++;
    end
    chk({tag, "_rest_quiet"}, bad, 0);
    cyc();
    chk({tag, "_step2"}, step_idx, 2);
    cyc();
    chk({tag, "_done"}, done, 1);
    chk({tag, "_idle"}, busy, 0);
    cyc();
    chk({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int d0, n_play, n_sil, bnd;
    reset = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0; prog_we = 1'b0;
    prog_addr = '0; prog_peak = '0; prog_dur = '0;
    repeat (3) cyc();
    chk("rst_busy", busy, 0);
    chk("rst_note_on", note_on, 0);
    chk("rst_done", done, 0);
    chk("rst_signal", signal, 0);
    chk("rst_step", step_idx, 0);
    reset = 1'b0;
    cyc();

    // 1: basic melody with a rest and an end marker
    prog(0, 3, 2);
    prog(1, 0, 1);
    prog(2, 5, 0);
    check_melody1("t1");

    // 2: looping through all steps, then natural end
    for (int s = 0; s < 4; s++) prog(s, 2, 1);
    loop_en = 1'b1;
    d0 = done_cnt;
    start_pulse();
    cyc();
    for (int k = 0; k < 5; k++) begin
      chk("t2_step", step_idx, k % 4);
      chk("t2_on", note_on, 1);
      repeat (P1) cyc();
    end
    // Now in the first PLAY cycle of step 1 in the second round.
    chk("t2_no_done", done_cnt - d0, 0);
    loop_en = 1'b0;
    repeat (2 * P1 + TICK_DIV + GAPC) cyc();
    chk("t2_end_done", done, 1);
    chk("t2_end_idle", busy, 0);

    // 3: stop mid-PLAY, start+stop together
    prog(0, 2, 1);
    prog(1, 4, 3);
    prog(2, 0, 0);
    d0 = done_cnt;
    start_pulse();
    cyc();
    repeat (P1) cyc();
    chk("t3_step1", step_idx, 1);
    cyc(); cyc();
    chk("t3_mid_sig", signal, 2);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("t3_stop_busy", busy, 0);
    chk("t3_stop_sig", signal, 0);
    chk("t3_stop_on", note_on, 0);
    repeat (20) cyc();
    chk("t3_no_done", done_cnt - d0, 0);
    start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    chk("t3_startstop_busy", busy, 0);
    cyc();
    chk("t3_startstop_busy2", busy, 0);

    // 4: writes ignored while busy, honoured while idle
    prog(0, 3, 2);
    prog(1, 0, 1);
    prog(2, 5, 0);
    start_pulse();
    cyc();
    prog(0, 7, 9);
    wait_done("t4_first_done");
    cyc();
    check_melody1("t4_replay");
    prog(0, 7, 9);
    start_pulse();
    for (int i = 0; i < 36; i++) begin
      cyc();
      if (i == 7)  chk("t4_new_peak", signal, 7);
      if (i == 8)  chk("t4_new_fall", signal, 6);
      if (i == 35) chk("t4_new_dur_last", note_on, 1);
    end
    cyc();
    chk("t4_new_dur_end", note_on, 0);
    wait_done("t4_second_done");
    cyc();

    // 5: end marker at step 0 with loop_en set
    prog(0, 5, 0);
    loop_en = 1'b1;
    start_pulse();
    chk("t5_load_busy", busy, 1);
    cyc();
    chk("t5_done", done, 1);
    chk("t5_idle", busy, 0);
    cyc();
    chk("t5_done_pulse", done, 0);
    chk("t5_stay_idle", busy, 0);
    loop_en = 1'b0;

    // 6: silence between two dur=1 notes (the LOAD cycle is always silent)
    prog(0, 2, 1);
    prog(1, 2, 1);
    prog(2, 0, 0);
    start_pulse();
    cyc();
    n_play = 0; bnd = 0;
    while (note_on === 1'b1 && bnd < 100) begin n_play++; bnd++; cyc(); end
    n_sil = 0; bnd = 0;
    while (note_on !== 1'b1 && busy === 1'b1 && bnd < 100) begin n_sil++; bnd++; cyc(); end
    chk("t6_play_len", n_play, TICK_DIV);
    chk("t6_silent_len", n_sil, GAPC + 1);
    chk("t6_second_step", step_idx, 1);
    wait_done("t6_done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
